msu_multi_regs: RTL and testbench

- Second-generation MSU register front end for the SNES bus, decoded at a parametrised base address.
- Generalises the single-channel MSU1 register block to NUM_CH independently controlled audio channels, selected through a channel-select register.
- Adds a prefetching data port: a FIFO of FIFO_DEPTH bytes filled over a req/valid fetch handshake, with a real seek-busy status.
- Sits between the SNES CPU bus and the MSU audio players / data-file fetcher.

---
 rtl/msu_multi_regs.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_msu_multi_regs.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/msu_multi_regs.sv
`default_nettype none
// ============================================================================
// msu_multi_regs : multi-channel MSU register front end with prefetching data port.
// Optional macro MSU_RESUME_EN adds per-channel audio_resume pulses.
// Revision: 1.0
// ============================================================================
module msu_multi_regs #(
    parameter logic [15:0] BASE_ADDR  = 16'h2000,
    parameter int          NUM_CH     = 2,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [2:0]  REVISION   = 3'd2
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   ENABLE,
    input  logic                   RD_N,
    input  logic                   WR_N,
    input  logic [23:0]            ADDR,
    input  logic [7:0]             DIN,
    output logic [7:0]             DOUT,
    output logic                   MSU_SEL,
    output logic                   fetch_req,
    output logic [31:0]            fetch_addr,
    input  logic                   fetch_valid,
    input  logic [7:0]             fetch_data,
    output logic [16*NUM_CH-1:0]   track_out,
    output logic [NUM_CH-1:0]      track_request,
    output logic [8*NUM_CH-1:0]    volume_out,
    output logic [NUM_CH-1:0]      audio_play,
    output logic [NUM_CH-1:0]      audio_repeat,
`ifdef MSU_RESUME_EN
    output logic [NUM_CH-1:0]      audio_resume,
`endif
    input  logic [NUM_CH-1:0]      track_mounting,
    input  logic [NUM_CH-1:0]      track_missing_in,
    input  logic [NUM_CH-1:0]      audio_playing_in
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(FIFO_DEPTH);
`ifdef MSU_RESUME_EN
    localparam logic [2:0] c_REV_BITS = REVISION | 3'b100;
`else
    localparam logic [2:0] c_REV_BITS = REVISION;
`endif

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_REQ     = 2'd1;
    localparam logic [1:0] c_DISCARD = 2'd2;

    // ---------------- bus strobe edge detection ----------------
    logic       rd_n_q, wr_n_q, rd_act_q, wr_act_q;
    logic [3:0] off_q;
    logic [7:0] din_q;
    logic [7:0] bank;

    assign bank    = ADDR[23:16];
    assign MSU_SEL = ENABLE
                   & ((bank <= 8'h3F) | ((bank >= 8'h80) & (bank <= 8'hBF)))
                   & (ADDR[15:4] == BASE_ADDR[15:4]);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            rd_act_q <= 1'b0;
            wr_act_q <= 1'b0;
            off_q    <= 4'd0;
            din_q    <= 8'd0;
        end else begin
            rd_n_q   <= RD_N;
            wr_n_q   <= WR_N;
            rd_act_q <= rd_n_q & ~RD_N & MSU_SEL;
            wr_act_q <= wr_n_q & ~WR_N & MSU_SEL;
            if ((rd_n_q & ~RD_N) | (wr_n_q & ~WR_N)) begin
                off_q <= ADDR[3:0];
                din_q <= DIN;
            end
        end
    end

    logic seek_commit, wr_trk_hi, wr_vol, wr_ctrl;
    assign seek_commit = wr_act_q && (off_q == 4'd3);
    assign wr_trk_hi   = wr_act_q && (off_q == 4'd5);
    assign wr_vol      = wr_act_q && (off_q == 4'd6);
    assign wr_ctrl     = wr_act_q && (off_q == 4'd7);

    // ---------------- shared registers ----------------
    logic [31:0]     seek_q;
    logic [7:0]      trk_lo_q;
    logic [CH_W-1:0] chsel_q;
    logic [7:0]      chsel_mod;

    assign chsel_mod = din_q % 8'(NUM_CH);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            seek_q   <= 32'd0;
            trk_lo_q <= 8'd0;
            chsel_q  <= '0;
        end else if (wr_act_q) begin
            case (off_q)
                4'd0: seek_q[7:0]   <= din_q;
                4'd1: seek_q[15:8]  <= din_q;
                4'd2: seek_q[23:16] <= din_q;
                4'd3: seek_q[31:24] <= din_q;
                4'd4: trk_lo_q      <= din_q;
                4'd8: chsel_q       <= chsel_mod[CH_W-1:0];
                default: ;
            endcase
        end
    end

    // ---------------- per-channel state ----------------
    logic [15:0]       track_q [NUM_CH];
    logic [7:0]        vol_q   [NUM_CH];
    logic [NUM_CH-1:0] play_q, rep_q, busy_q, miss_q, treq_q;
    logic [NUM_CH-1:0] mount_q, missin_q, playing_q;
`ifdef MSU_RESUME_EN
    logic [NUM_CH-1:0] resume_q;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                track_q[i] <= 16'd0;
                vol_q[i]   <= 8'hFF;
            end
            play_q    <= '0;
            rep_q     <= '0;
            busy_q    <= '0;
            miss_q    <= '0;
            treq_q    <= '0;
            mount_q   <= '0;
            missin_q  <= '0;
            playing_q <= '0;
`ifdef MSU_RESUME_EN
            resume_q  <= '0;
`endif
        end else begin
            mount_q   <= track_mounting;
            missin_q  <= track_missing_in;
            playing_q <= audio_playing_in;
            treq_q    <= '0;
`ifdef MSU_RESUME_EN
            resume_q  <= '0;
`endif
            for (int i = 0; i < NUM_CH; i++) begin
                // Later assignments win: missing-rise over mount-fall, bus write over all.
                if (track_mounting[i] & ~mount_q[i])
                    busy_q[i] <= 1'b1;
                if (~track_mounting[i] & mount_q[i]) begin
                    busy_q[i] <= 1'b0;
                    miss_q[i] <= track_missing_in[i];
                end
                if (~audio_playing_in[i] & playing_q[i]) begin
                    play_q[i] <= 1'b0;
                    busy_q[i] <= 1'b0;
                end
                if (track_missing_in[i] & ~missin_q[i]) begin
                    miss_q[i] <= 1'b1;
                    busy_q[i] <= 1'b0;
                end
                if (CH_W'(i) == chsel_q) begin
                    if (wr_trk_hi) begin
                        track_q[i] <= {din_q, trk_lo_q};
                        treq_q[i]  <= 1'b1;
                        miss_q[i]  <= 1'b0;
                        vol_q[i]   <= 8'hFF;
                    end
                    if (wr_vol)
                        vol_q[i] <= din_q;
                    if (wr_ctrl && !busy_q[i]) begin
                        rep_q[i] <= din_q[1];
                        if (!miss_q[i]) begin
                            play_q[i] <= din_q[0];
`ifdef MSU_RESUME_EN
                            resume_q[i] <= din_q[0] & din_q[2];
`endif
                        end
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch_out
        assign track_out[16*g +: 16] = track_q[g];
        assign volume_out[8*g +: 8]  = vol_q[g];
    end

    assign track_request = treq_q;
    assign audio_play    = play_q;
    assign audio_repeat  = rep_q;
`ifdef MSU_RESUME_EN
    assign audio_resume  = resume_q;
`endif

    // ---------------- data prefetch FSM and FIFO ----------------
    logic [1:0]       state_q, state_d;
    logic [31:0]      fetch_addr_q;
    logic             data_busy_q, seeked_once_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic             push, pop;

    assign push = (state_q == c_REQ) && fetch_valid && !seek_commit;
    assign pop  = rd_act_q && (off_q == 4'd1) && (count_q != '0);

    always_ff @(posedge CLK) begin
        if (RESET)
            state_q <= c_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (seek_commit) begin
            // An unanswered old fetch must drain before the new address is issued.
            if ((state_q != c_IDLE) && !fetch_valid)
                state_d = c_DISCARD;
            else
                state_d = c_REQ;
        end else begin
            case (state_q)
                c_IDLE:    if (seeked_once_q && (count_q < c_DEPTH)) state_d = c_REQ;
                c_REQ:     if (fetch_valid) state_d = c_IDLE;
                c_DISCARD: if (fetch_valid) state_d = c_REQ;
                default:   state_d = c_IDLE;
            endcase
        end
    end

    always_comb begin
        fetch_req = (state_q == c_REQ);
    end

    assign fetch_addr = fetch_addr_q;

    always_ff @(posedge CLK) begin
        if (push)
            mem_q[wptr_q] <= fetch_data;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_addr_q  <= 32'd0;
            data_busy_q   <= 1'b0;
            seeked_once_q <= 1'b0;
            count_q       <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
        end else if (seek_commit) begin
            fetch_addr_q  <= {din_q, seek_q[23:0]};
            data_busy_q   <= 1'b1;
            seeked_once_q <= 1'b1;
            count_q       <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
        end else begin
            if (push) begin
                fetch_addr_q <= fetch_addr_q + 32'd1;
                data_busy_q  <= 1'b0;
                wptr_q       <= wptr_q + 1'b1;
            end
            if (pop)
                rptr_q <= rptr_q + 1'b1;
            if (push && !pop)
                count_q <= count_q + 1'b1;
            else if (pop && !push)
                count_q <= count_q - 1'b1;
        end
    end

    // ---------------- read data ----------------
    logic [7:0] dout_q;
    logic [7:0] status;

    assign status = {data_busy_q, busy_q[chsel_q], rep_q[chsel_q], play_q[chsel_q],
                     miss_q[chsel_q], c_REV_BITS};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            dout_q <= 8'd0;
        end else if (rd_act_q) begin
            case (off_q)
                4'd0: dout_q <= status;
                4'd1: dout_q <= (count_q != '0) ? mem_q[rptr_q] : 8'h00;
                4'd2: dout_q <= 8'h53;
                4'd3: dout_q <= 8'h2D;
                4'd4: dout_q <= 8'h4D;
                4'd5: dout_q <= 8'h53;
                4'd6: dout_q <= 8'h55;
                4'd7: dout_q <= 8'h32;
                4'd8: dout_q <= 8'(chsel_q);
                default: ;
            endcase
        end
    end

    assign DOUT = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_msu_multi_regs.sv
`default_nettype none
// tb_msu_multi_regs : directed scoreboard bench for msu_multi_regs.
module tb_msu_multi_regs;

`ifdef MSU_RESUME_EN
    localparam logic [2:0] REV = 3'd6;
`else
    localparam logic [2:0] REV = 3'd2;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        RESET, ENABLE, RD_N, WR_N;
    logic [23:0] ADDR;
    logic [7:0]  DIN, DOUT;
    logic        MSU_SEL, fetch_req, fetch_valid;
    logic [31:0] fetch_addr;
    logic [7:0]  fetch_data;
    logic [31:0] track_out;
    logic [1:0]  track_request, audio_play, audio_repeat;
    logic [15:0] volume_out;
    logic [1:0]  track_mounting, track_missing_in, audio_playing_in;
`ifdef MSU_RESUME_EN
    logic [1:0]  audio_resume;
`endif

    msu_multi_regs #(
        .BASE_ADDR(16'h2000), .NUM_CH(2), .FIFO_DEPTH(8), .REVISION(3'd2)
    ) dut (
        .CLK(clk), .RESET(RESET), .ENABLE(ENABLE), .RD_N(RD_N), .WR_N(WR_N),
        .ADDR(ADDR), .DIN(DIN), .DOUT(DOUT), .MSU_SEL(MSU_SEL),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .track_out(track_out), .track_request(track_request),
        .volume_out(volume_out), .audio_play(audio_play), .audio_repeat(audio_repeat),
`ifdef MSU_RESUME_EN
        .audio_resume(audio_resume),
`endif
        .track_mounting(track_mounting), .track_missing_in(track_missing_in),
        .audio_playing_in(audio_playing_in)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Read scoreboard: expectation queued when the strobe is driven, popped on DOUT.
    logic [7:0] exp_q[$];
    string      tag_q[$];

    task automatic bus_read(input logic [23:0] a, input logic [7:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk); #1;
        ADDR = a; RD_N = 1'b0;
        repeat (3) @(posedge clk); #1;
        RD_N = 1'b1;
        repeat (2) @(posedge clk); #1;
        check(tag_q.pop_front(), {24'h0, DOUT}, {24'h0, exp_q.pop_front()});
    endtask

    task automatic bus_write(input logic [23:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        ADDR = a; DIN = d; WR_N = 1'b0;
        repeat (3) @(posedge clk); #1;
        WR_N = 1'b1;
        repeat (2) @(posedge clk); #1;
    endtask

    // Fetch responder: answers each request after resp_delay cycles with addr[7:0] (or AA once).
    int          resp_delay = 3;
    bit          resp_en    = 1'b1;
    bit          ovr        = 1'b0;
    logic [31:0] seen[$];

    initial begin
        logic [31:0] a;
        logic [7:0]  d;
        fetch_valid = 1'b0;
        fetch_data  = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (fetch_req && resp_en) begin
                a = fetch_addr;
                seen.push_back(a);
                d = ovr ? 8'hAA : a[7:0];
                ovr = 1'b0;
                repeat (resp_delay - 1) @(posedge clk);
                #1;
                fetch_valid = 1'b1;
                fetch_data  = d;
                @(posedge clk); #1;
                fetch_valid = 1'b0;
            end
        end
    end

    int         tr_cnt = 0;
    logic [1:0] tr_last = 2'b00;
    always @(negedge clk) begin
        if (track_request != 2'b00) begin
            tr_cnt++;
            tr_last = track_request;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET = 1'b1; ENABLE = 1'b1; RD_N = 1'b1; WR_N = 1'b1;
        ADDR = 24'h0; DIN = 8'h0;
        track_mounting = 2'b00; track_missing_in = 2'b00; audio_playing_in = 2'b00;
        repeat (5) @(posedge clk); #1;
        check("rst_dout", {24'h0, DOUT}, 32'h0);
        check("rst_req", {31'h0, fetch_req}, 32'h0);
        check("rst_addr", fetch_addr, 32'h0);
        check("rst_track", track_out, 32'h0);
        check("rst_vol", {16'h0, volume_out}, 32'h0000FFFF);
        check("rst_play", {28'h0, audio_play, audio_repeat}, 32'h0);
        RESET = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Window decode
        ADDR = 24'h402000; #1; check("sel_bank40", {31'h0, MSU_SEL}, 32'h0);
        ADDR = 24'h002005; #1; check("sel_bank00", {31'h0, MSU_SEL}, 32'h1);
        ADDR = 24'hBF200F; #1; check("sel_bankBF", {31'h0, MSU_SEL}, 32'h1);
        ADDR = 24'h002010; #1; check("sel_off10", {31'h0, MSU_SEL}, 32'h0);
        ENABLE = 1'b0;     #1; check("sel_disabled", {31'h0, MSU_SEL}, 32'h0);
        ENABLE = 1'b1;

        // ID and status
        bus_read(24'h002002, 8'h53, "id_S");
        bus_read(24'h002003, 8'h2D, "id_dash");
        bus_read(24'h002004, 8'h4D, "id_M");
        bus_read(24'h002005, 8'h53, "id_S2");
        bus_read(24'h002006, 8'h55, "id_U");
        bus_read(24'h002007, 8'h32, "id_2");
        bus_read(24'h002000, {5'b0, REV}, "status_reset");
        bus_read(24'h402000, {5'b0, REV}, "bank40_no_effect");

        // Seek and stream
        resp_en = 1'b0;
        bus_write(24'h002000, 8'h00);
        bus_write(24'h002001, 8'h10);
        bus_write(24'h002002, 8'h00);
        bus_write(24'h002003, 8'h00);
        check("seek_req", {31'h0, fetch_req}, 32'h1);
        check("seek_addr", fetch_addr, 32'h00001000);
        bus_read(24'h002000, {5'b10000, REV}, "status_data_busy");
        resp_en = 1'b1;
        repeat (60) @(posedge clk); #1;
        check("full_req_low", {31'h0, fetch_req}, 32'h0);
        check("full_fetch_count", seen.size(), 32'd8);
        bus_read(24'h002000, {5'b0, REV}, "status_not_busy");
        for (int i = 0; i < 10; i++)
            bus_read(24'h002001, 8'(i), $sformatf("stream_%0d", i));
        check("fetch_addr0", seen[0], 32'h00001000);
        check("fetch_addr1", seen[1], 32'h00001001);
        check("fetch_addr2", seen[2], 32'h00001002);
        repeat (60) @(posedge clk); #1;

        // Empty FIFO
        resp_en = 1'b0;
        bus_write(24'h002000, 8'h10);
        bus_write(24'h002001, 8'h30);
        bus_write(24'h002002, 8'h00);
        bus_write(24'h002003, 8'h00);
        bus_read(24'h002001, 8'h00, "empty_read0");
        bus_read(24'h002001, 8'h00, "empty_read1");
        resp_en = 1'b1;
        repeat (60) @(posedge clk); #1;
        bus_read(24'h002001, 8'h10, "after_empty0");
        bus_read(24'h002001, 8'h11, "after_empty1");
        repeat (60) @(posedge clk); #1;

        // Seek while a fetch is outstanding
        seen.delete();
        resp_delay = 40;
        ovr = 1'b1;
        bus_write(24'h002000, 8'h00);
        bus_write(24'h002001, 8'h40);
        bus_write(24'h002002, 8'h00);
        bus_write(24'h002003, 8'h00);
        resp_delay = 3;
        bus_write(24'h002000, 8'h20);
        bus_write(24'h002001, 8'h00);
        bus_write(24'h002002, 8'h00);
        bus_write(24'h002003, 8'h00);
        repeat (80) @(posedge clk); #1;
        check("old_fetch_addr", seen[0], 32'h00004000);
        check("new_fetch_addr", seen[1], 32'h00000020);
        bus_read(24'h002001, 8'h20, "discard_read");

        // Channel select
        bus_write(24'h002008, 8'h01);
        bus_read(24'h002008, 8'h01, "chsel_read");
        bus_write(24'h002008, 8'h03);
        bus_read(24'h002008, 8'h01, "chsel_mod");
        bus_write(24'h002006, 8'h40);
        check("vol1_write", {16'h0, volume_out}, 32'h000040FF);
        tr_cnt = 0;
        bus_write(24'h002004, 8'h05);
        bus_write(24'h002005, 8'h00);
        check("track1", {16'h0, track_out[31:16]}, 32'h0005);
        check("track0", {16'h0, track_out[15:0]}, 32'h0000);
        check("treq_count", tr_cnt, 32'd1);
        check("treq_value", {30'h0, tr_last}, 32'h2);
        check("vol_after_trk", {16'h0, volume_out}, 32'h0000FFFF);

        // Busy gating and status events on channel 1
        track_mounting = 2'b10;
        repeat (3) @(posedge clk); #1;
        bus_write(24'h002007, 8'h01);
        check("busy_play_blocked", {30'h0, audio_play}, 32'h0);
        bus_read(24'h002000, {5'b01000, REV}, "status_busy");
        track_mounting = 2'b00;
        repeat (3) @(posedge clk); #1;
        bus_write(24'h002007, 8'h03);
        check("play1", {30'h0, audio_play}, 32'h2);
        check("repeat1", {30'h0, audio_repeat}, 32'h2);
        bus_read(24'h002000, {5'b00110, REV}, "status_playing");
        audio_playing_in = 2'b10;
        repeat (3) @(posedge clk); #1;
        audio_playing_in = 2'b00;
        repeat (3) @(posedge clk); #1;
        check("play_stopped", {30'h0, audio_play}, 32'h0);
        track_missing_in = 2'b10;
        repeat (2) @(posedge clk); #1;
        track_missing_in = 2'b00;
        repeat (2) @(posedge clk); #1;
        bus_read(24'h002000, {5'b00101, REV}, "status_missing");
        bus_write(24'h002007, 8'h01);
        check("missing_play_blocked", {30'h0, audio_play}, 32'h0);
        check("missing_repeat_cleared", {30'h0, audio_repeat}, 32'h0);
        bus_write(24'h002008, 8'h00);
        bus_read(24'h002000, {5'b0, REV}, "status_ch0");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
